// File: rtl/ro_freq_meter_pkg.sv
// ro_freq_meter shared types and defaults.
// State encoding and window sizes shared with the UART word FSM.
package ro_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int unsigned DEF_GATE_CYCLES   = 100000;
  localparam int unsigned DEF_SETTLE_CYCLES = 1000;
  localparam int unsigned DEF_CNT_W         = 32;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_freq_meter_edge_sync.sv
// edge_sync: 3-flop synchronizer with rising-edge pulse.
// Ports: clk, reset_n (async low), d (async in), pulse (1-cycle).
module edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: gated RO edge counter with settle + handshake.
// Ports: clk, reset_n, ro_in, start, abort, ro_en, busy, result*.
module ro_freq_meter
  import ro_freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ro_in,
  input  logic             start,
  input  logic             abort,
  output logic             ro_en,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow
);

  localparam int unsigned TW =
    $clog2(max2(GATE_CYCLES, SETTLE_CYCLES));
  localparam logic [TW-1:0] G_LOAD = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] S_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             en;
  logic             pulse;

  edge_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ro_in),
    .pulse   (pulse)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      timer <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      en    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SETTLE;
            timer <= S_LOAD;
            en    <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            en    <= 1'b0;
          end else if (timer == '0) begin
            state <= GATE;
            timer <= G_LOAD;
            cnt   <= '0;
            ovf   <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GATE: begin
          // Saturate: a pulse at full scale flags the lost edge.
          if (pulse) begin
            if (cnt == CNT_MAX) ovf <= 1'b1;
            else                cnt <= cnt + CNT_W'(1);
          end
          // Abort overrides the count update above.
          if (abort) begin
            state <= IDLE;
            en    <= 1'b0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end else if (timer == '0) begin
            state <= HOLD;
            en    <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        HOLD: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ro_en        = en;
  assign busy         = (state != IDLE);
  assign result_valid = (state == HOLD);
  assign result       = cnt;
  assign overflow     = ovf;

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: randomized check against an edge-time model.
// Two meters share stimulus: 32-bit and 4-bit (saturating) counts.
module tb_ro_freq_meter;

  localparam int G  = 100;
  localparam int S  = 8;
  localparam int WS = 4;
  localparam int SMAX = (1 << WS) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic ro_in = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic result_ready = 1'b0;

  logic        ro_en, busy, rv, ovf;
  logic [31:0] res;
  logic        ro_en_s, busy_s, rv_s, ovf_s;
  logic [WS-1:0] res_s;

  ro_freq_meter #(
    .GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(32)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .ro_in(ro_in),
    .start(start), .abort(abort), .ro_en(ro_en),
    .busy(busy), .result(res), .result_valid(rv),
    .result_ready(result_ready), .overflow(ovf)
  );

  ro_freq_meter #(
    .GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(WS)
  ) u_sat (
    .clk(clk), .reset_n(reset_n), .ro_in(ro_in),
    .start(start), .abort(abort), .ro_en(ro_en_s),
    .busy(busy_s), .result(res_s), .result_valid(rv_s),
    .result_ready(result_ready), .overflow(ovf_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Oscillator source; logs the posedge index right after each rise.
  bit ro_on = 1'b0;
  int hp_min = 2;
  int hp_max = 2;
  int hcnt = 1;
  int edges[$];

  always @(negedge clk) begin
    if (!ro_on) begin
      ro_in = 1'b0;
      hcnt = 1;
    end else begin
      hcnt--;
      if (hcnt <= 0) begin
        ro_in = ~ro_in;
        if (ro_in) edges.push_back(cyc + 1);
        hcnt = $urandom_range(hp_max, hp_min);
      end
    end
  end

  // A rise first sampled at posedge e reaches the counter at e+2;
  // it counts if that posedge lies inside the window.
  function automatic int model_count(input int p0);
    int n = 0;
    foreach (edges[i])
      if (edges[i] + 2 >= p0 + S + 1 && edges[i] + 2 <= p0 + S + G)
        n++;
    return n;
  endfunction

  task automatic do_start(output int t, output int p0);
    @(negedge clk);
    start = 1'b1;
    t  = cyc;
    p0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int t);
    int k;
    for (k = 0; k < 400; k++) begin
      if (rv) break;
      @(negedge clk);
    end
    if (k == 400) chk("valid_timeout", 0, 1);
    else chk("latency", cyc - t, S + G + 1);
  endtask

  task automatic check_result(input int p0);
    int m;
    m = model_count(p0);
    chk("result", res, m);
    chk("overflow", ovf, 0);
    chk("sat_result", res_s, (m > SMAX) ? SMAX : m);
    chk("sat_overflow", ovf_s, (m > SMAX) ? 1 : 0);
  endtask

  task automatic handshake();
    @(negedge clk);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("hs_busy", busy, 0);
    chk("hs_valid", rv, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ro_en"}, ro_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_result"}, res, 0);
    chk({tag, "_valid"}, rv, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_sat_busy"}, busy_s, 0);
    chk({tag, "_sat_result"}, res_s, 0);
  endtask

  task automatic scan_idle(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (rv || busy || ro_en) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, p0, d;

    #1 reset_n = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("post_reset");

    // Basic count, period 4, ready held high.
    hp_min = 2; hp_max = 2; ro_on = 1'b1;
    result_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_ro_en", ro_en, 0);
    do_start(t, p0);
    chk("start_ro_en", ro_en, 1);
    chk("start_busy", busy, 1);
    wait_valid(t);
    chk("basic_25", res, 25);
    check_result(p0);
    @(negedge clk);
    chk("basic_done", busy, 0);
    result_ready = 1'b0;

    // Randomized periods, phases and ready delays.
    for (int i = 0; i < 8; i++) begin
      hp_min = 2;
      hp_max = $urandom_range(6, 2);
      ro_on = ($urandom_range(7, 0) != 0);
      repeat ($urandom_range(9, 1)) @(negedge clk);
      do_start(t, p0);
      wait_valid(t);
      check_result(p0);
      d = $urandom_range(5, 0);
      repeat (d) @(negedge clk);
      chk("rand_hold", rv, 1);
      handshake();
    end

    // Back-pressure: result stable while ro_in keeps toggling.
    hp_min = 2; hp_max = 2; ro_on = 1'b1;
    do_start(t, p0);
    wait_valid(t);
    chk("bp_25", res, 25);
    check_result(p0);
    repeat (50) begin
      @(negedge clk);
      chk("bp_result", res, 25);
      chk("bp_busy", busy, 1);
      chk("bp_valid", rv, 1);
    end
    handshake();

    // Abort 30 cycles into the window.
    do_start(t, p0);
    while (cyc < p0 + S + 30) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ro_en", ro_en, 0);
    chk("abort_busy", busy, 0);
    scan_idle("abort_no_valid", S + G + 20);
    do_start(t, p0);
    wait_valid(t);
    chk("after_abort_25", res, 25);
    check_result(p0);
    handshake();

    // Abort in IDLE alongside start: start wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    t = cyc; p0 = cyc + 1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_wins", busy, 1);
    wait_valid(t);
    check_result(p0);
    handshake();

    // Ignored starts with a silent input.
    ro_on = 1'b0;
    repeat (4) @(negedge clk);
    do_start(t, p0);
    while (cyc < p0 + 3) @(negedge clk);
    pulse_start();
    while (cyc < p0 + S + 20) @(negedge clk);
    pulse_start();
    wait_valid(t);
    pulse_start();
    chk("silent_0", res, 0);
    check_result(p0);
    handshake();
    scan_idle("one_result", S + G + 20);

    // Reset during the window.
    ro_on = 1'b1;
    do_start(t, p0);
    while (cyc < p0 + S + 40) @(negedge clk);
    reset_n = 1'b0;
    #1 check_zero("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    scan_idle("stay_idle", 200);
    do_start(t, p0);
    wait_valid(t);
    check_result(p0);
    handshake();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Gated edge counter that measures one ring-oscillator output over a fixed window of system clocks and produces a 32-bit count. It is the stage directly upstream of the UART word-transmit FSM, which consumes one `result` per handshake and sends it as four bytes MSB-first. The meter also drives the enable of the oscillator under test, with a settle interval before counting, so the top level only selects which RO is routed to `ro_in` and issues `start`.

## Interface
- `GATE_CYCLES`, default 100000: length of the counting window in `clk` cycles (≥ 2).
- `SETTLE_CYCLES`, default 1000: cycles between `ro_en` rising and window start (≥ 1).
- `CNT_W`, default 32: width of `result`.
- `clk`  in  1  system clock; all logic runs on this single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ro_in`  in  1  asynchronous oscillator output, already divided upstream to below clk/2.
- `start`  in  1  one-cycle request to run a measurement.
- `abort`  in  1  cancel the measurement in progress.
- `ro_en`  out  1  enable to the oscillator under test.
- `busy`  out  1  high in every state except IDLE.
- `result`  out  CNT_W  measured edge count.
- `result_valid`  out  1  `result` is valid.
- `result_ready`  in  1  consumer accepts `result`.
- `overflow`  out  1  the count saturated; qualified by `result_valid`.

## Operation
- `ro_in` passes through a 2-flop synchronizer, then a third flop. A rising edge is the pulse `s2 & ~s3`.
- States:
  - IDLE: `start` → SETTLE. The timer loads `SETTLE_CYCLES-1` and `ro_en` is set.
  - SETTLE: the timer counts down. At 0 → GATE, the timer loads `GATE_CYCLES-1` and the edge counter clears.
  - GATE: each edge pulse adds 1 to the counter. At timer 0 → HOLD. The edge pulse in that last cycle is still counted. `ro_en` clears on entry to HOLD.
  - HOLD: `result_valid` is 1. `result` and `overflow` are stable. On `result_valid & result_ready` → IDLE.
- Saturation: the counter stops at 2^CNT_W−1 and sets `overflow`. It does not wrap.
- `start` outside IDLE is ignored. It is not queued.
- `abort` in SETTLE or GATE → IDLE. `ro_en` clears, no result is produced, and the counter is discarded. `abort` in HOLD is ignored; the result must be consumed.
- `start` and `abort` in the same cycle in IDLE: `start` wins. `abort` has no effect in IDLE.
- Edge pulses outside GATE are discarded, including synchronizer residue from SETTLE.

## Timing
- Reset values: `ro_en`=0, `busy`=0, `result`=0, `result_valid`=0, `overflow`=0. The state is IDLE and the synchronizer flops are 0.
- `start` sampled high in cycle T:
  - `ro_en` and `busy` go high at T+1.
  - GATE occupies T+1+SETTLE_CYCLES through T+SETTLE_CYCLES+GATE_CYCLES.
  - `result_valid` goes high at T+1+SETTLE_CYCLES+GATE_CYCLES.
- Latency from an `ro_in` edge to its counted pulse: 2–3 cycles. Edges near the window boundaries are attributed by pulse time only.
- `result_valid` holds until the handshake. `busy` and `result_valid` drop the cycle after `result_ready` is seen. A new `start` is accepted from that cycle on.
- Asserting `reset_n` low mid-measurement immediately returns every output to its reset value.

## Structure
- A shared package holds:
  - the state enum (IDLE, SETTLE, GATE, HOLD) and its 2-bit encoding;
  - the default `GATE_CYCLES`, `SETTLE_CYCLES` and `CNT_W`, which are also used by the UART word FSM.
- One sub-module, `edge_sync`: the 3-flop synchronizer plus rising-edge pulse, with asynchronous active-low reset. It is reused by other RO-sampling blocks.
- The timer is sized `$clog2(max(GATE_CYCLES, SETTLE_CYCLES))` bits.

## Test plan
- Basic count: `GATE_CYCLES`=100, `SETTLE_CYCLES`=8, `ro_in` period 4 clk, one `start`, `result_ready`=1 → `result`=25, `overflow`=0, `result_valid` exactly 109 cycles after the `start` cycle.
- Back-pressure: as in basic count but `result_ready`=0 for 50 cycles → `result`=25 held stable, `busy`=1. `ro_in` toggling during HOLD does not change `result`. One handshake → IDLE.
- Abort: `abort` 30 cycles into GATE → `ro_en`=0 next cycle and no `result_valid`. A following `start` gives `result`=25.
- Saturation: `CNT_W`=4, `ro_in` period 4, `GATE_CYCLES`=100 → `result`=15, `overflow`=1.
- Ignored `start`, silent input: `start` pulsed during SETTLE, GATE and HOLD → exactly one result. `ro_in` held at 0 → `result`=0.
- Reset mid-operation: `reset_n` low during GATE → all outputs 0 immediately. After release, the meter stays in IDLE until `start`.
